// File: rtl/pifo_deq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pifo_deq_ctrl
// Brief   : Paced PIFO head remover feeding a first-word-fall-through FIFO.
// Revision: 1.0
// ============================================================================
module pifo_deq_ctrl #(
  parameter int RANK_WIDTH    = 10,
  parameter int META_WIDTH    = 20,
  parameter int L2_FIFO_DEPTH = 2,
  parameter int HOLDOFF       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     pifo_valid_out,
  input  logic [RANK_WIDTH-1:0]    pifo_rank_out,
  input  logic [META_WIDTH-1:0]    pifo_meta_out,
  output logic                     pifo_remove,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [RANK_WIDTH-1:0]    m_rank,
  output logic [META_WIDTH-1:0]    m_meta,
  output logic [L2_FIFO_DEPTH:0]   fifo_level,
  output logic [31:0]              deq_count
);

  localparam int                    DEPTH      = 2 ** L2_FIFO_DEPTH;
  localparam int                    ENTRY_W    = RANK_WIDTH + META_WIDTH;
  localparam logic [L2_FIFO_DEPTH:0] LEVEL_FULL = (L2_FIFO_DEPTH + 1)'(DEPTH);
  localparam logic [3:0]            HOLD_LOAD  = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               hold_q, hold_d;
  logic [L2_FIFO_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [L2_FIFO_DEPTH:0]   level_q, level_d;
  logic [31:0]              deq_count_q;
  logic [ENTRY_W-1:0]       mem_q [DEPTH];

  logic push, pop;

  // Full check deliberately ignores a same-cycle pop.
  assign pifo_remove = rst && (state_q == S_IDLE) && enable && pifo_valid_out
                       && (level_q < LEVEL_FULL);
  assign push        = pifo_remove;
  assign m_valid     = (level_q != '0);
  assign pop         = m_valid && m_ready;

  assign m_rank      = m_valid ? mem_q[rd_ptr_q][ENTRY_W-1:META_WIDTH] : '0;
  assign m_meta      = m_valid ? mem_q[rd_ptr_q][META_WIDTH-1:0]       : '0;
  assign fifo_level  = level_q;
  assign deq_count   = deq_count_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (pifo_remove && (HOLDOFF > 0)) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (hold_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (L2_FIFO_DEPTH + 1)'(1);
      2'b01:   level_d = level_q - (L2_FIFO_DEPTH + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hold_q      <= 4'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      deq_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      if (push) begin
        wr_ptr_q    <= wr_ptr_q + L2_FIFO_DEPTH'(1);
        deq_count_q <= deq_count_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + L2_FIFO_DEPTH'(1);
      end
    end
  end

  // Storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pifo_rank_out, pifo_meta_out};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pifo_deq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pifo_deq_ctrl
// Brief   : Directed bench; instance a uses HOLDOFF=2, instance b HOLDOFF=0.
// Revision: 1.0
// ============================================================================
module tb_pifo_deq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  logic        a_rst, a_en, a_valid, a_ready, a_remove, a_mvalid;
  logic [9:0]  a_rank, a_mrank;
  logic [19:0] a_meta, a_mmeta;
  logic [2:0]  a_level;
  logic [31:0] a_deq;

  logic        b_rst, b_en, b_valid, b_ready, b_remove, b_mvalid;
  logic [9:0]  b_rank, b_mrank;
  logic [19:0] b_meta, b_mmeta;
  logic [2:0]  b_level;
  logic [31:0] b_deq;

  pifo_deq_ctrl #(.RANK_WIDTH(10), .META_WIDTH(20), .L2_FIFO_DEPTH(2), .HOLDOFF(2)) dut_a (
    .clk(clk), .rst(a_rst), .enable(a_en), .pifo_valid_out(a_valid),
    .pifo_rank_out(a_rank), .pifo_meta_out(a_meta), .pifo_remove(a_remove),
    .m_valid(a_mvalid), .m_ready(a_ready), .m_rank(a_mrank), .m_meta(a_mmeta),
    .fifo_level(a_level), .deq_count(a_deq)
  );

  pifo_deq_ctrl #(.RANK_WIDTH(10), .META_WIDTH(20), .L2_FIFO_DEPTH(2), .HOLDOFF(0)) dut_b (
    .clk(clk), .rst(b_rst), .enable(b_en), .pifo_valid_out(b_valid),
    .pifo_rank_out(b_rank), .pifo_meta_out(b_meta), .pifo_remove(b_remove),
    .m_valid(b_mvalid), .m_ready(b_ready), .m_rank(b_mrank), .m_meta(b_mmeta),
    .fifo_level(b_level), .deq_count(b_deq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one full cycle; returns just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b0; a_en = 1'b0; a_valid = 1'b0; a_ready = 1'b0; a_rank = '0; a_meta = '0;
    b_rst = 1'b0; b_en = 1'b1; b_valid = 1'b1; b_ready = 1'b0; b_rank = '0; b_meta = '0;
    #3;
    chk("rst_a_mvalid", 64'(a_mvalid), 64'd0);
    chk("rst_a_level",  64'(a_level),  64'd0);
    chk("rst_a_deq",    64'(a_deq),    64'd0);
    chk("rst_a_mrank",  64'(a_mrank),  64'd0);
    chk("rst_b_remove_gated", 64'(b_remove), 64'd0);
    tick();
    chk("rst_b_remove_after_edge", 64'(b_remove), 64'd0);
    b_en  = 1'b0;
    a_rst = 1'b1;
    b_rst = 1'b1;

    // Single entry with HOLDOFF=2
    a_en = 1'b1; a_valid = 1'b1; a_rank = 10'd5; a_meta = 20'h00ABC;
    #1 chk("A_remove0", 64'(a_remove), 64'd1);
    tick();
    chk("A_hold1_remove", 64'(a_remove), 64'd0);
    chk("A_mvalid",       64'(a_mvalid), 64'd1);
    chk("A_mrank",        64'(a_mrank),  64'd5);
    chk("A_mmeta",        64'(a_mmeta),  64'h00ABC);
    chk("A_level",        64'(a_level),  64'd1);
    chk("A_deq",          64'(a_deq),    64'd1);
    a_rank = 10'd6; a_meta = 20'h00006;
    tick();
    chk("A_hold2_remove", 64'(a_remove), 64'd0);
    tick();
    chk("A_idle_remove",  64'(a_remove), 64'd1);
    tick();
    chk("A_level2",       64'(a_level),  64'd2);
    tick();
    tick();
    a_rank = 10'd7; a_meta = 20'h00007;
    #1 chk("A_third_remove", 64'(a_remove), 64'd1);
    tick();
    chk("A_level3", 64'(a_level), 64'd3);
    chk("A_head5",  64'(a_mrank), 64'd5);
    chk("A_deq3",   64'(a_deq),   64'd3);

    // Asynchronous reset mid-HOLD with three entries buffered
    #2 a_rst = 1'b0;
    #1;
    chk("D_mvalid", 64'(a_mvalid), 64'd0);
    chk("D_level",  64'(a_level),  64'd0);
    chk("D_deq",    64'(a_deq),    64'd0);
    chk("D_remove", 64'(a_remove), 64'd0);
    chk("D_mrank",  64'(a_mrank),  64'd0);
    a_valid = 1'b0;
    @(negedge clk);
    a_rst = 1'b1;

    // Counter wrap
    force dut_a.deq_count_q = 32'hFFFF_FFFF;
    #1 release dut_a.deq_count_q;
    #1 chk("E_deq_preset", 64'(a_deq), 64'hFFFF_FFFF);
    a_valid = 1'b1; a_rank = 10'd9;
    #1 chk("E_remove", 64'(a_remove), 64'd1);
    tick();
    a_valid = 1'b0;
    chk("E_deq_wrap", 64'(a_deq), 64'd0);

    // Enable gating on b (valid held high since reset)
    repeat (14) tick();
    chk("G_remove_disabled", 64'(b_remove), 64'd0);
    chk("G_deq_zero",        64'(b_deq),    64'd0);

    // Full stall with HOLDOFF=0
    b_en = 1'b1; b_rank = 10'd1; b_meta = 20'd1;
    #1 chk("G_remove_same_cycle", 64'(b_remove), 64'd1);
    tick(); b_rank = 10'd2; b_meta = 20'd2;
    #1 chk("B_remove2", 64'(b_remove), 64'd1);
    tick(); b_rank = 10'd3; b_meta = 20'd3;
    tick(); b_rank = 10'd4; b_meta = 20'd4;
    tick(); b_rank = 10'd5; b_meta = 20'd5;
    #1 chk("B_full_remove", 64'(b_remove), 64'd0);
    chk("B_full_level", 64'(b_level), 64'd4);
    chk("B_full_head",  64'(b_mrank), 64'd1);
    chk("B_full_deq",   64'(b_deq),   64'd4);
    b_ready = 1'b1;
    #1 chk("B_pop_no_space", 64'(b_remove), 64'd0);
    tick();
    b_ready = 1'b0;
    #1 chk("B_after_pop_level",  64'(b_level),  64'd3);
    chk("B_after_pop_head",   64'(b_mrank),  64'd2);
    chk("B_after_pop_remove", 64'(b_remove), 64'd1);
    tick();
    b_valid = 1'b0;
    chk("B_refill_level", 64'(b_level), 64'd4);
    chk("B_refill_deq",   64'(b_deq),   64'd5);
    b_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      #1 chk($sformatf("B_drain_rank%0d", i), 64'(b_mrank), 64'(i));
      chk($sformatf("B_drain_meta%0d", i), 64'(b_mmeta), 64'(i));
      tick();
    end
    chk("B_empty_level",  64'(b_level),  64'd0);
    chk("B_empty_mvalid", 64'(b_mvalid), 64'd0);
    chk("B_empty_mrank",  64'(b_mrank),  64'd0);

    // Streaming through pointer wrap
    b_rst = 1'b0;
    #1 chk("C_rst_deq", 64'(b_deq), 64'd0);
    b_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_rank = 10'(i); b_meta = 20'(i + 100); b_valid = 1'b1;
      tick();
      chk($sformatf("C_rank%0d", i),  64'(b_mrank), 64'(i));
      chk($sformatf("C_meta%0d", i),  64'(b_mmeta), 64'(i + 100));
      chk($sformatf("C_level%0d", i), 64'(b_level), 64'd1);
    end
    b_valid = 1'b0;
    tick();
    chk("C_final_level", 64'(b_level), 64'd0);
    chk("C_final_deq",   64'(b_deq),   64'd10);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pifo_deq_ctrl.md
PIFO_DEQ_CTRL -- requirements
Module: pifo_deq_ctrl

Interface
REQ-001 Parameter RANK_WIDTH, default 10, rank field width; it SHALL match the attached PIFO.
REQ-002 Parameter META_WIDTH, default 20, metadata field width; it SHALL match the attached PIFO.
REQ-003 Parameter L2_FIFO_DEPTH, default 2, log2 of the output FIFO depth (DEPTH = 2**L2_FIFO_DEPTH, so 4 by default).
REQ-004 Parameter HOLDOFF, default 2, the number of idle cycles enforced after each remove; legal range 0..15.
REQ-005 clk  input  1  single clock; every register SHALL be clocked on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 enable  input  1  when 1, the block SHALL be permitted to issue removes.
REQ-008 pifo_valid_out  input  1  the PIFO head is valid.
REQ-009 pifo_rank_out  input  RANK_WIDTH  PIFO head rank.
REQ-010 pifo_meta_out  input  META_WIDTH  PIFO head metadata.
REQ-011 pifo_remove  output  1  remove request to the PIFO; it SHALL be combinational from registered state and inputs.
REQ-012 m_valid  output  1  the downstream head entry is valid.
REQ-013 m_ready  input  1  the downstream consumer accepts the head entry.
REQ-014 m_rank  output  RANK_WIDTH  downstream head rank.
REQ-015 m_meta  output  META_WIDTH  downstream head metadata.
REQ-016 fifo_level  output  L2_FIFO_DEPTH+1  current output FIFO occupancy.
REQ-017 deq_count  output  32  total removes issued since reset.

Function
REQ-018 The block SHALL have two states: IDLE and HOLD.
REQ-019 pifo_remove SHALL be 1 exactly when all of the following are true: state is IDLE, enable=1, pifo_valid_out=1, and fifo_level<DEPTH.
REQ-020 Capture rule: in the same cycle that pifo_remove=1, the block SHALL sample pifo_rank_out and pifo_meta_out and write them into the FIFO tail at that clock edge.
REQ-021 The FIFO full check SHALL use the registered fifo_level only; a same-cycle pop SHALL NOT create space for a push.
REQ-022 State transitions:
- IDLE to HOLD when pifo_remove=1 and HOLDOFF>0; the hold counter loads HOLDOFF-1.
- With HOLDOFF=0, the block SHALL stay in IDLE, allowing back-to-back removes.
- HOLD counts down by 1 each cycle; HOLD to IDLE on the cycle the counter equals 0.
- pifo_remove SHALL be 0 throughout HOLD.
REQ-023 The FIFO SHALL be first-word-fall-through:
- m_valid = (fifo_level != 0).
- m_rank and m_meta SHALL present the head entry while m_valid=1, and SHALL be 0 while empty.
REQ-024 A pop SHALL occur when m_valid & m_ready; the head pointer advances by 1 modulo DEPTH.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged and advance both pointers.
REQ-026 Read and write pointers SHALL be L2_FIFO_DEPTH bits wide and wrap from DEPTH-1 to 0.
REQ-027 m_ready asserted while m_valid=0 SHALL have no effect.
REQ-028 deq_count SHALL increment by 1 on each cycle with pifo_remove=1, and SHALL wrap from 2**32-1 to 0.
REQ-029 Deasserting enable SHALL block new removes only. An active HOLD SHALL continue counting down, and FIFO draining SHALL continue.
REQ-030 If pifo_valid_out drops while the block is in IDLE, no remove SHALL be issued and no state SHALL change.
REQ-031 Order preservation: entries SHALL leave m_* in exactly the order they were removed from the PIFO.

Reset
REQ-032 Asserting rst=0 SHALL immediately, regardless of clk, set all of the following:
- state = IDLE, hold counter = 0;
- FIFO pointers = 0, fifo_level = 0, deq_count = 0;
- m_valid = 0, m_rank = 0, m_meta = 0, pifo_remove = 0.
REQ-033 While rst=0, pifo_remove SHALL be 0 regardless of all other inputs.
REQ-034 Reset asserted mid-HOLD or with a non-empty FIFO SHALL discard all buffered entries.
REQ-035 After rst returns to 1, the first remove SHALL be permitted on the next rising edge.
REQ-036 FIFO storage need not be reset.

Verification
REQ-037 Single entry: HOLDOFF=2, enable=1, m_ready=0, PIFO presents rank 5 / meta 0x00ABC -> pifo_remove=1 for exactly one cycle; next cycle m_valid=1, m_rank=5, m_meta=0x00ABC, fifo_level=1; no further remove for 2 cycles.
REQ-038 Full stall: HOLDOFF=0, m_ready=0, pifo_valid_out held at 1 with ranks 1,2,3,4,5 -> exactly 4 removes in 4 consecutive cycles; fifo_level=4; pifo_remove=0 thereafter. Then one m_ready pulse pops rank 1, and the next cycle issues remove of rank 5.
REQ-039 Streaming wrap: HOLDOFF=0, m_ready=1 constantly, 10 entries with ranks 0..9 -> output ranks 0..9 in order; fifo_level never exceeds 1; deq_count=10.
REQ-040 Enable gating: enable=0 with pifo_valid_out=1 for 20 cycles -> pifo_remove=0 and deq_count=0; enable=1 -> remove in the same cycle.
REQ-041 Async reset: rst driven 0 between clock edges with fifo_level=3 and state HOLD -> outputs clear immediately: m_valid=0, fifo_level=0, deq_count=0, pifo_remove=0.
REQ-042 Counter wrap: deq_count forced to 0xFFFFFFFF, then one remove -> deq_count=0.
